// File: rtl/menu_key_square.sv
// Menu key icon: pixel hit-test with press-down animation and key accept pulse.
// Optional MENU_KEY_BLINK_EN: icon blinks while the key is held.
module menu_key_square #(
  parameter logic [10:0] TOP_LEFT_X = 11'd288,
  parameter logic [10:0] TOP_LEFT_Y = 11'd224,
  parameter int OBJECT_WIDTH_X = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int PRESS_FRAMES = 8,
  parameter int PRESS_SHIFT = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        keyPress,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        keyAccepted
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [11:0] X_LO = {1'b0, TOP_LEFT_X};
  localparam logic [11:0] X_HI = X_LO + 12'(OBJECT_WIDTH_X);

  state_t      state;
  logic [3:0]  frame_cnt;
  logic [10:0] shift_y;
  logic [11:0] top_y;
  logic [11:0] bot_y;
  logic [11:0] px;
  logic [11:0] py;
  logic        hit;
  logic        show;

`ifdef MENU_KEY_BLINK_EN
  logic [3:0]  blink_cnt;
`endif

  assign px    = {1'b0, pixelX};
  assign py    = {1'b0, pixelY};
  assign top_y = {1'b0, TOP_LEFT_Y} + {1'b0, shift_y};
  assign bot_y = top_y + 12'(OBJECT_HEIGHT_Y);

  // Hit test against the icon box, shifted down while pressed
  always_comb begin
    hit = (px >= X_LO) && (px < X_HI) &&
          (py >= top_y) && (py < bot_y);
    show = 1'b1;
`ifdef MENU_KEY_BLINK_EN
    if (state == HOLD && blink_cnt[3])
      show = 1'b0;
`endif
  end

  // Key FSM, frame counters and registered pixel outputs
  always_ff @(posedge clk) begin
    if (!resetN || !enable) begin
      state           <= IDLE;
      frame_cnt       <= 4'd0;
      shift_y         <= 11'd0;
      InsideRectangle <= 1'b0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
      keyAccepted     <= 1'b0;
`ifdef MENU_KEY_BLINK_EN
      blink_cnt       <= 4'd0;
`endif
    end else begin
      keyAccepted <= 1'b0;
      if (hit && show) begin
        InsideRectangle <= 1'b1;
        offsetX         <= pixelX - TOP_LEFT_X;
        offsetY         <= py[10:0] - top_y[10:0];
      end else begin
        InsideRectangle <= 1'b0;
        offsetX         <= 11'd0;
        offsetY         <= 11'd0;
      end
      if (startOfFrame) begin
        unique case (state)
          IDLE: begin
            if (keyPress) begin
              state       <= PRESSED;
              frame_cnt   <= 4'(PRESS_FRAMES - 1);
              shift_y     <= 11'(PRESS_SHIFT);
              keyAccepted <= 1'b1;
            end
          end
          PRESSED: begin
            if (frame_cnt != 4'd0) begin
              frame_cnt <= frame_cnt - 4'd1;
            end else begin
              shift_y <= 11'd0;
              state   <= keyPress ? HOLD : IDLE;
`ifdef MENU_KEY_BLINK_EN
              blink_cnt <= 4'd0;
`endif
            end
          end
          HOLD: begin
            if (!keyPress)
              state <= IDLE;
`ifdef MENU_KEY_BLINK_EN
            else
              blink_cnt <= blink_cnt + 4'd1;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_menu_key_square.sv
// Randomized bench for menu_key_square against a frame-level model.
// Default build (blink disabled).
module tb_menu_key_square;

  localparam int TX = 288;
  localparam int TY = 224;
  localparam int W = 32;
  localparam int H = 32;
  localparam int PF = 8;
  localparam int PS = 2;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        enable;
  logic        keyPress;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        keyAccepted;

  int checks = 0;
  int failures = 0;
  int accepts = 0;

  bit m_busy;
  bit m_hold;
  int m_since;
  int m_shift;

  bit          e_in;
  logic [10:0] e_ox;
  logic [10:0] e_oy;
  bit          e_acc;

  menu_key_square dut (
    .clk(clk),
    .resetN(resetN),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .startOfFrame(startOfFrame),
    .enable(enable),
    .keyPress(keyPress),
    .InsideRectangle(InsideRectangle),
    .offsetX(offsetX),
    .offsetY(offsetY),
    .keyAccepted(keyAccepted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a press is accepted on a frame start while nothing is going on;
  // the icon stays shifted for PF frames, then either holds or idles.
  task automatic model(input bit rst, input bit en, input bit sof,
                       input bit key, input int x, input int y);
    int top;
    e_acc = 0;
    if (!rst || !en) begin
      m_busy = 0; m_hold = 0; m_since = 0; m_shift = 0;
      e_in = 0; e_ox = 0; e_oy = 0;
      return;
    end
    top = TY + m_shift;
    e_in = (x >= TX) && (x < TX + W) && (y >= top) && (y < top + H);
    e_ox = e_in ? 11'(x - TX) : 11'd0;
    e_oy = e_in ? 11'(y - top) : 11'd0;
    if (sof) begin
      if (m_busy) begin
        m_since++;
        if (m_since == PF) begin
          m_busy = 0;
          m_shift = 0;
          m_hold = key;
        end
      end else if (m_hold) begin
        if (!key) m_hold = 0;
      end else if (key) begin
        m_busy = 1;
        m_since = 0;
        m_shift = PS;
        e_acc = 1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit sof,
                      input bit key, input int x, input int y);
    @(negedge clk);
    resetN = rst;
    enable = en;
    startOfFrame = sof;
    keyPress = key;
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(posedge clk);
    model(rst, en, sof, key, x, y);
    #1;
    chk("inside", 32'(InsideRectangle), 32'(e_in));
    chk("offsetX", 32'(offsetX), 32'(e_ox));
    chk("offsetY", 32'(offsetY), 32'(e_oy));
    chk("keyAccepted", 32'(keyAccepted), 32'(e_acc));
    if (keyAccepted === 1'b1) accepts++;
  endtask

  initial begin
    bit key;
    bit en;
    bit rst;
    bit sof;
    resetN = 0; enable = 1; startOfFrame = 0; keyPress = 0;
    pixelX = 0; pixelY = 0;
    m_busy = 0; m_hold = 0; m_since = 0; m_shift = 0;

    step(0, 1, 0, 0, TX, TY);
    chk("rst_inside", 32'(InsideRectangle), 32'd0);
    chk("rst_acc", 32'(keyAccepted), 32'd0);

    step(1, 1, 0, 0, 288, 224);
    chk("idle_corner", 32'(InsideRectangle), 32'd1);
    step(1, 1, 0, 0, 320, 224);
    chk("right_edge", 32'(InsideRectangle), 32'd0);
    step(1, 1, 0, 0, 319, 255);
    chk("last_pixel", 32'(InsideRectangle), 32'd1);

    step(1, 1, 1, 1, 0, 0);
    chk("press_acc", 32'(keyAccepted), 32'd1);
    step(1, 1, 0, 1, 288, 226);
    chk("pulse_1clk", 32'(keyAccepted), 32'd0);
    chk("shift_top", 32'(InsideRectangle), 32'd1);
    chk("shift_offy", 32'(offsetY), 32'd0);
    step(1, 1, 0, 1, 288, 225);
    chk("shift_above", 32'(InsideRectangle), 32'd0);
    step(1, 1, 0, 1, 290, 257);
    chk("shift_bottom", 32'(InsideRectangle), 32'd1);

    // Hold through the animation: 8 more SOFs, last one enters HOLD
    for (int i = 0; i < PF; i++) begin
      step(1, 1, 1, 1, 0, 0);
      step(1, 1, 0, 1, 288, 224);
    end
    chk("hold_unshifted", 32'(InsideRectangle), 32'd1);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    chk("second_acc", 32'(keyAccepted), 32'd1);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 290, 240);
    chk("disable_inside", 32'(InsideRectangle), 32'd0);

    key = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) != 0);
      en = ($urandom_range(0, 79) != 0);
      sof = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) key = ~key;
      step(rst, en, sof, key,
           $urandom_range(TX - 8, TX + W + 8),
           $urandom_range(TY - 8, TY + H + 8));
    end
    chk("saw_accepts", 32'(accepts > 4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
